// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, drives the instruction memory
// address, fills the IF/ID register and handles stall, redirect, halt and
// out-of-range fetch faults.
module fetch_controller #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD      = 32'h0000_000C,
  parameter int unsigned IMEM_BYTE_BITS = 11
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectTarget,
  output logic [31:0] InstrAddress,
  input  logic [31:0] InstrData,
  output logic [31:0] ID_Instruction,
  output logic [31:0] ID_PCPlus4,
  output logic        ID_Valid,
  output logic        Halted,
  output logic        Fault,
  output logic [31:0] FetchCount
);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALTED
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] id_instruction, id_instruction_n;
  logic [31:0] id_pcplus4, id_pcplus4_n;
  logic        id_valid, id_valid_n;
  logic        fault, fault_n;
  logic [31:0] fetch_count, fetch_count_n;

  logic [31:0] redirect_pc;
  logic [31:0] pc_plus4;
  logic        in_range;

  // Target is word-aligned by masking the low two bits.
  assign redirect_pc = RedirectTarget & ~32'h0000_0003;
  assign pc_plus4    = pc + 32'd4;
  assign in_range    = (pc >> IMEM_BYTE_BITS) == '0;

  // State and pipeline registers; reset overrides every other input.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state          <= BOOT;
      pc             <= RESET_PC;
      id_instruction <= '0;
      id_pcplus4     <= '0;
      id_valid       <= 1'b0;
      fault          <= 1'b0;
      fetch_count    <= '0;
    end else begin
      state          <= state_n;
      pc             <= pc_n;
      id_instruction <= id_instruction_n;
      id_pcplus4     <= id_pcplus4_n;
      id_valid       <= id_valid_n;
      fault          <= fault_n;
      fetch_count    <= fetch_count_n;
    end
  end

  // Next-state and next-register logic: redirect > stall > range fault > fetch.
  always_comb begin
    state_n          = state;
    pc_n             = pc;
    id_instruction_n = id_instruction;
    id_pcplus4_n     = id_pcplus4;
    id_valid_n       = id_valid;
    fault_n          = fault;
    fetch_count_n    = fetch_count;
    unique case (state)
      BOOT: begin
        id_valid_n = 1'b0;
        state_n    = RUN;
      end
      RUN: begin
        if (Redirect) begin
          pc_n       = redirect_pc;
          id_valid_n = 1'b0;
        end else if (Stall) begin
          // hold everything
        end else if (!in_range) begin
          id_valid_n = 1'b0;
          fault_n    = 1'b1;
          state_n    = HALTED;
        end else begin
          id_instruction_n = InstrData;
          id_pcplus4_n     = pc_plus4;
          id_valid_n       = 1'b1;
          fetch_count_n    = fetch_count + 32'd1;
          if (InstrData == HALT_WORD) begin
            state_n = HALTED;
          end else begin
            pc_n = pc_plus4;
          end
        end
      end
      HALTED: begin
        id_valid_n = 1'b0;
        // A fault is sticky: only reset leaves HALTED once it is set.
        if (Redirect && !fault) begin
          pc_n    = redirect_pc;
          state_n = RUN;
        end
      end
      default: begin
        state_n = BOOT;
      end
    endcase
  end

  assign InstrAddress   = pc;
  assign ID_Instruction = id_instruction;
  assign ID_PCPlus4     = id_pcplus4;
  assign ID_Valid       = id_valid;
  assign Halted         = (state == HALTED);
  assign Fault          = fault;
  assign FetchCount     = fetch_count;

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed scenarios then random stimulus,
// all checked cycle by cycle against a behavioural fetch model.
module tb_fetch_controller;

  localparam logic [31:0] HALT = 32'h0000_000C;
  localparam int unsigned LIMIT = 2048;

  logic        Clk;
  logic        Reset;
  logic        Stall;
  logic        Redirect;
  logic [31:0] RedirectTarget;
  logic [31:0] InstrAddress;
  logic [31:0] InstrData;
  logic [31:0] ID_Instruction;
  logic [31:0] ID_PCPlus4;
  logic        ID_Valid;
  logic        Halted;
  logic        Fault;
  logic [31:0] FetchCount;

  logic [31:0] mem [0:511];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: mode 0 = boot, 1 = running, 2 = halted.
  int          m_mode;
  logic [31:0] m_pc, m_instr, m_pc4, m_count;
  bit          m_valid, m_fault;

  fetch_controller #(
    .RESET_PC(32'h0000_0000),
    .HALT_WORD(HALT),
    .IMEM_BYTE_BITS(11)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .Stall(Stall),
    .Redirect(Redirect),
    .RedirectTarget(RedirectTarget),
    .InstrAddress(InstrAddress),
    .InstrData(InstrData),
    .ID_Instruction(ID_Instruction),
    .ID_PCPlus4(ID_PCPlus4),
    .ID_Valid(ID_Valid),
    .Halted(Halted),
    .Fault(Fault),
    .FetchCount(FetchCount)
  );

  assign InstrData = mem[InstrAddress[10:2]];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input bit rst, input bit stl, input bit rdr, input logic [31:0] tgt);
    logic [31:0] word;
    logic [31:0] aligned;
    word    = mem[(m_pc / 4) % 512];
    aligned = tgt - (tgt % 4);
    if (rst) begin
      m_mode = 0; m_pc = 0; m_instr = 0; m_pc4 = 0;
      m_valid = 0; m_fault = 0; m_count = 0;
    end else if (m_mode == 0) begin
      m_valid = 0;
      m_mode  = 1;
    end else if (m_mode == 1) begin
      if (rdr) begin
        m_pc    = aligned;
        m_valid = 0;
      end else if (stl) begin
      end else if (m_pc >= LIMIT) begin
        m_valid = 0;
        m_fault = 1;
        m_mode  = 2;
      end else begin
        m_instr = word;
        m_pc4   = m_pc + 4;
        m_valid = 1;
        m_count = m_count + 1;
        if (word == HALT) m_mode = 2;
        else m_pc = m_pc + 4;
      end
    end else begin
      m_valid = 0;
      if (rdr && !m_fault) begin
        m_pc   = aligned;
        m_mode = 1;
      end
    end
  endtask

  // One clock: drive inputs, advance model on the edge, compare just after.
  task automatic step(input bit rst, input bit stl, input bit rdr, input logic [31:0] tgt);
    Reset = rst; Stall = stl; Redirect = rdr; RedirectTarget = tgt;
    @(posedge Clk);
    model_edge(rst, stl, rdr, tgt);
    #1;
    check("pc", InstrAddress, m_pc);
    check("valid", {31'b0, ID_Valid}, {31'b0, m_valid});
    if (m_valid || rst) begin
      check("instr", ID_Instruction, m_instr);
      check("pc4", ID_PCPlus4, m_pc4);
    end
    check("halted", {31'b0, Halted}, {31'b0, (m_mode == 2)});
    check("fault", {31'b0, Fault}, {31'b0, m_fault});
    check("count", FetchCount, m_count);
  endtask

  initial begin
    Reset = 1'b1; Stall = 1'b0; Redirect = 1'b0; RedirectTarget = '0;
    for (int i = 0; i < 512; i++) mem[i] = i * 3;
    mem[4] = 32'h0000_0100;  // keep i*3 from producing the halt encoding

    // Reset then streaming fetch: boot bubble, then 0,3,6,9 (word 4 replaced).
    step(1, 0, 0, 0);
    check("rst_instr", ID_Instruction, 32'h0);
    step(0, 0, 0, 0);
    check("boot_valid", {31'b0, ID_Valid}, 32'h0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    check("cnt4", FetchCount, 32'd4);
    check("last_instr", ID_Instruction, 32'd9);

    // Stall held three cycles with PC=8.
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    check("stall_instr", ID_Instruction, 32'd3);
    check("stall_pc", InstrAddress, 32'd8);
    step(0, 0, 0, 0);
    check("rel_instr", ID_Instruction, 32'd6);
    check("rel_pc", InstrAddress, 32'd12);

    // Redirect beats Stall; low target bits dropped.
    step(0, 1, 1, 32'h0000_0043);
    check("rd_pc", InstrAddress, 32'h40);
    step(0, 0, 0, 0);
    check("rd_instr", ID_Instruction, 32'd48);
    check("rd_pc4", ID_PCPlus4, 32'h44);

    // Halt word at address 20, then resume via Redirect to 0.
    mem[5] = HALT;
    step(0, 0, 1, 32'h0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
    check("halt_word", ID_Instruction, HALT);
    step(0, 1, 0, 0);
    check("halt_flag", {31'b0, Halted}, 32'h1);
    check("halt_pc", InstrAddress, 32'd20);
    mem[5] = 32'd15;
    step(0, 0, 1, 32'h0);
    step(0, 0, 0, 0);
    check("resume_instr", ID_Instruction, 32'd0);
    check("resume_halted", {31'b0, Halted}, 32'h0);

    // Out-of-range fetch faults and sticks until reset.
    step(0, 0, 1, 32'h0000_0800);
    step(0, 0, 0, 0);
    check("fault_set", {31'b0, Fault}, 32'h1);
    step(0, 0, 1, 32'h0);
    step(0, 0, 0, 0);
    check("fault_pc", InstrAddress, 32'h800);
    step(1, 0, 0, 0);
    check("fault_clr", {31'b0, Fault}, 32'h0);

    // Reset mid-stream with Redirect asserted.
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    step(1, 0, 1, 32'h0000_0100);
    check("mid_rst_pc", InstrAddress, 32'h0);

    // Random phase: random memory with occasional halt words.
    for (int i = 0; i < 512; i++)
      mem[i] = ($urandom_range(0, 99) < 3) ? HALT : $urandom;
    for (int c = 0; c < 1500; c++) begin
      bit          r_rst, r_stl, r_rdr;
      logic [31:0] r_tgt;
      r_rst = ($urandom_range(0, 99) < 2);
      r_stl = ($urandom_range(0, 99) < 20);
      r_rdr = ($urandom_range(0, 99) < 8);
      r_tgt = ($urandom_range(0, 99) < 90) ? 32'($urandom_range(0, 2047)) : $urandom;
      step(r_rst, r_stl, r_rdr, r_tgt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Instruction-fetch sequencer for the single-clock MIPS datapath. It owns the program counter and drives the instruction memory's 32-bit byte address, whose read is combinational. It captures the returned word into the IF/ID pipeline register and handles hazard stalls, branch/jump redirects, halt detection and out-of-range fetch faults. It sits between the instruction memory and the decode stage.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- HALT_WORD, 32'h0000_000C (syscall), instruction encoding that stops fetching.
- IMEM_BYTE_BITS, 11, byte-address width backed by instruction memory (word index = PC[10:2]).

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Stall  in  1  hazard unit hold request for PC and IF/ID.
- Redirect  in  1  branch/jump resolved taken; flush and reload PC.
- RedirectTarget  in  32  new PC; bits [1:0] are forced to 0 internally.
- InstrAddress  out  32  byte address to instruction memory; equals PC register.
- InstrData  in  32  instruction word returned combinationally for InstrAddress.
- ID_Instruction  out  32  IF/ID instruction.
- ID_PCPlus4  out  32  IF/ID PC+4 of that instruction.
- ID_Valid  out  1  IF/ID holds a real instruction (0 = bubble).
- Halted  out  1  controller in HALTED state.
- Fault  out  1  sticky; fetch attempted outside the implemented range.
- FetchCount  out  32  number of instructions delivered with ID_Valid=1.

## Operation
- FSM states: BOOT, RUN, HALTED.
- Reset (sampled on edge, overrides everything): state=BOOT, PC=RESET_PC, ID_Instruction=0, ID_PCPlus4=0, ID_Valid=0, Halted=0, Fault=0, FetchCount=0.
- BOOT: lasts one cycle for memory settle; no capture, ID_Valid=0; next state RUN.
- RUN, priority per cycle (highest first):
  1. Redirect: PC <= {RedirectTarget[31:2],2'b00}; ID_Valid <= 0; IF/ID data don't-care; Stall ignored.
  2. Stall: PC, IF/ID, FetchCount all hold.
  3. Range fault (PC[31:IMEM_BYTE_BITS] != 0): no capture, ID_Valid <= 0, Fault <= 1, state -> HALTED.
  4. Normal: ID_Instruction <= InstrData, ID_PCPlus4 <= PC+4, ID_Valid <= 1, FetchCount += 1, PC <= PC+4. If InstrData == HALT_WORD, it is still delivered (valid, counted), PC holds, and the state goes to HALTED.
- HALTED: Halted=1; ID_Valid <= 0 each cycle; PC and FetchCount hold; Stall ignored.
  - Redirect in HALTED (halt word was on a wrong path) loads the PC as in RUN, clears Halted and returns to RUN.
  - Fault is sticky: when Fault=1, Redirect is ignored and only Reset exits.
- PC arithmetic is 32-bit modulo 2^32. Wrap past 32'hFFFF_FFFC is reachable only via Redirect and is caught by the range check.
- FetchCount wraps modulo 2^32.

## Timing
- InstrAddress is combinational from the PC register; no memory-side handshake.
- Fetch latency: the word at PC=A appears on ID_Instruction with ID_Valid=1 exactly one cycle after the first unstalled RUN cycle with PC=A.
- Throughput: one instruction per cycle when Stall=0 and Redirect=0.
- Redirect penalty: one bubble (ID_Valid=0) in the cycle after the Redirect edge. The target instruction becomes valid the cycle after that.
- Stall and Redirect together: Redirect wins, and the stalled IF/ID contents are flushed.
- Halted rises in the cycle after the halt word is captured, the same cycle its ID_Valid=1 is visible.
- Reset asserted mid-stream: the next edge yields reset values regardless of Stall, Redirect or state.

## Test plan
- Reset, memory word i = i*3, Stall=0: cycle 1 BOOT ID_Valid=0; then ID_Instruction = 0,3,6,9 with ID_PCPlus4 = 4,8,12,16; FetchCount=4 after four valid cycles.
- Stall held 3 cycles while PC=8: ID_Instruction stays 3, PC stays 8, FetchCount frozen; on release the next capture is 6 and the PC advances to 12.
- Redirect to 32'h0000_0043 while Stall=1: next cycle ID_Valid=0 and InstrAddress=32'h40; the following cycle ID_Instruction=memory[16]=48 with ID_PCPlus4=32'h44.
- Halt word at address 20: it is delivered with ID_Valid=1, then Halted=1, ID_Valid=0 and the PC holds at 20. A later Redirect to 0 resumes fetch with instruction 0 and Halted=0.
- Redirect to 32'h0000_0800 (IMEM_BYTE_BITS=11): the next RUN cycle sets Fault=1 and Halted=1 with no valid capture; a further Redirect is ignored; Reset clears all outputs.
- Reset asserted mid-stream with Redirect=1: the next cycle shows PC=RESET_PC, state BOOT and all outputs at their reset values.
